// File: rtl/dac_spi_scheduler_pkg.sv
// Shared definitions for the DAC SPI frame scheduler: FSM encoding,
// frame geometry and the 24-bit frame packing helper.
package dac_spi_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam int SPI_LEN = 24;
  localparam logic [3:0] CMD_DEFAULT = 4'b0011;

  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  function automatic logic [SPI_LEN-1:0] pack_frame(input logic [3:0] cmd,
                                                    input logic [3:0] addr,
                                                    input logic [15:0] data);
    logic [SPI_LEN-1:0] f;
    f = '0;
    f[CMD_MSB:CMD_LSB]   = cmd;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:DATA_LSB] = data;
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_scheduler_if.sv
// Requester and SPI-master side signals of the DAC frame scheduler.
interface dac_spi_scheduler_if #(
  parameter int NCH = 4
);
  // Handshake: req[i] is a level held by the requester until ack[i] pulses
  // for one cycle; spi_en is a start strobe held until spi_sync_n goes low,
  // and the frame is complete when spi_sync_n returns high.
  logic [NCH-1:0]                                 req;
  logic [NCH*16-1:0]                              wdata;
  logic [NCH-1:0]                                 ack;
  logic [dac_spi_scheduler_pkg::SPI_LEN-1:0]      spi_data;
  logic                                           spi_en;
  logic                                           spi_sync_n;
  logic                                           err;
  logic                                           busy;

  modport slave (
    input  req, wdata, spi_sync_n,
    output ack, spi_data, spi_en, err, busy
  );

  modport master (
    output req, wdata, spi_sync_n,
    input  ack, spi_data, spi_en, err, busy
  );
endinterface

// File: rtl/dac_spi_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: search starts one past the last served channel.
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int IDXW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]  req,
  input  logic [IDXW-1:0] last_grant,
  output logic [NCH-1:0]  gnt,
  output logic [IDXW-1:0] idx,
  output logic            valid
);
  int pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 0; k < NCH; k++) begin
      pos = (int'(last_grant) + 1 + k) % NCH;
      if (!valid && req[pos]) begin
        valid    = 1'b1;
        idx      = IDXW'(pos);
        gnt[pos] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dac_spi_scheduler.sv
// Schedules per-channel DAC writes onto a single SPI master, one frame at a
// time, round-robin, with start timeout and a fixed inter-frame gap.
module dac_spi_scheduler
  import dac_spi_scheduler_pkg::*;
#(
  parameter int         NCH     = 4,
  parameter int         GAP_CYC = 4,
  parameter int         TIMEOUT = 64,
  parameter logic [3:0] CMD     = CMD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dac_spi_scheduler_if.slave    bus,
  output state_e                state_dbg
);
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int GW   = $clog2(GAP_CYC + 1);

  state_e               state;
  logic [IDXW-1:0]      last_grant;
  logic [IDXW-1:0]      grant_idx;
  logic [NCH-1:0]       grant_oh;
  logic [TW-1:0]        to_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [NCH-1:0]       ack_r;
  logic [SPI_LEN-1:0]   spi_data_r;
  logic                 spi_en_r;
  logic                 err_r;

  logic [NCH-1:0]       arb_gnt;
  logic [IDXW-1:0]      arb_idx;
  logic                 arb_valid;

  rr_arbiter #(.NCH(NCH), .IDXW(IDXW)) u_arb (
    .req        (bus.req),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .idx        (arb_idx),
    .valid      (arb_valid)
  );

  // last_grant advances only on a completed frame, so a timed-out channel
  // keeps its turn and is retried first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= IDXW'(NCH - 1);
      grant_idx  <= '0;
      grant_oh   <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      ack_r      <= '0;
      spi_data_r <= '0;
      spi_en_r   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      ack_r <= '0;
      err_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_idx  <= arb_idx;
            grant_oh   <= arb_gnt;
            spi_data_r <= pack_frame(CMD, 4'(arb_idx), bus.wdata[16*arb_idx +: 16]);
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          spi_en_r <= 1'b1;
          to_cnt   <= '0;
          state    <= ST_START;
        end
        ST_START: begin
          if (!bus.spi_sync_n) begin
            spi_en_r <= 1'b0;
            state    <= ST_SHIFT;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            spi_en_r <= 1'b0;
            err_r    <= 1'b1;
            gap_cnt  <= '0;
            state    <= ST_GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.spi_sync_n) begin
            ack_r      <= grant_oh;
            last_grant <= grant_idx;
            gap_cnt    <= '0;
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack      = ack_r;
  assign bus.spi_data = spi_data_r;
  assign bus.spi_en   = spi_en_r;
  assign bus.err      = err_r;
  assign bus.busy     = (state != ST_IDLE);
  assign state_dbg    = state;
endmodule

// File: doc/dac_spi_scheduler.md
DAC_SPI_SCHEDULER -- requirements
Module: dac_spi_scheduler

Interface
REQ-001 Parameter NCH, default 4: number of requesting DAC channels (2..8).
REQ-002 Parameter GAP_CYC, default 4: minimum idle clk cycles between frames, with sync_n high.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles from spi_en rise until spi_sync_n is seen low.
REQ-004 Parameter CMD, default 4'b0011: command nibble, write-and-update.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req  in  NCH  per-channel request level; held until the matching ack.
REQ-008 wdata  in  NCH*16  per-channel DAC code; channel i occupies bits [16i+15:16i].
REQ-009 ack  out  NCH  one-cycle pulse; the channel's frame has completed on the wire.
REQ-010 spi_data  out  24  frame to the SPI master data_in.
REQ-011 spi_en  out  1  start strobe to the SPI master en.
REQ-012 spi_sync_n  in  1  SPI master sync_n; low while a frame is shifting.
REQ-013 err  out  1  one-cycle pulse on timeout abort.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM states SHALL be IDLE, LOAD, START, SHIFT, GAP.
REQ-016 IDLE: if any req bit is high, grant the round-robin winner, capture {CMD, 4'(grant), wdata[grant]} into spi_data, and go to LOAD next cycle.
REQ-017 Round-robin: search starts at (last_grant+1) mod NCH; last_grant resets to NCH-1, so channel 0 wins first.
REQ-018 spi_data SHALL stay constant from LOAD until exit from SHIFT; wdata changes after grant are ignored.
REQ-019 LOAD lasts exactly 1 cycle, giving the master a cycle to sample spi_data; then go to START.
REQ-020 START: spi_en=1; stay in START until spi_sync_n==0, then go to SHIFT.
REQ-021 START timeout: after TIMEOUT cycles in START, deassert spi_en, pulse err, give no ack, keep req pending, and go to GAP.
REQ-022 SHIFT: spi_en=0; on the first cycle with spi_sync_n==1, pulse ack[grant] and go to GAP.
REQ-023 GAP: count GAP_CYC cycles, then go to IDLE; requests seen during GAP wait for IDLE.
REQ-024 Latency: req high in IDLE at cycle N -> spi_data valid at N+1, spi_en high at N+2.
REQ-025 ack SHALL be one-hot or zero; err and ack are never high in the same cycle.
REQ-026 A requester dropping req before ack SHALL NOT abort a frame already granted; ack still pulses.
REQ-027 Simultaneous requests on all channels: each channel is served once per NCH frames; no starvation.
REQ-028 The timeout counter width SHALL be clog2(TIMEOUT+1); GAP counter width clog2(GAP_CYC+1); no wrap-around is possible.

Reset
REQ-029 Reset values: FSM=IDLE, spi_en=0, spi_data=0, ack=0, err=0, busy=0, last_grant=NCH-1, all counters=0.
REQ-030 Reset mid-frame: spi_en drops immediately (asynchronous); the interrupted frame is not acked; the master is reset by the same rst_n.

Structure
REQ-031 Shared package: state encoding, SPI_LEN=24, the CMD default, and the frame field positions (cmd [23:20], addr [19:16], data [15:0]).
REQ-032 One sub-module, rr_arbiter (NCH-wide, rotating priority, outputs a one-hot grant plus an index), is natural; the FSM and frame formatting stay in the top level.

Verification
REQ-033 req=4'b0001, wdata0=16'h8000 -> spi_data=24'h308000; spi_en rises 2 cycles after req; ack[0] pulses once after sync_n returns high.
REQ-034 req=4'b1111 held, each req dropped on its ack -> grant order 0,1,2,3; GAP_CYC idle cycles between frames.
REQ-035 spi_sync_n tied high -> err pulses after 64 START cycles; no ack; the same channel is retried after GAP.
REQ-036 rst_n low during SHIFT -> spi_en=0 and busy=0 at once; no ack; after reset, a pending req is served from channel 0.
REQ-037 wdata1 changes during SHIFT -> the shifted frame keeps the originally captured code; ack[1] is a single pulse.
REQ-038 With the real SPI master attached, serial dout bits reconstruct spi_data MSB-first for 8 random frames.
